// File: rtl/sound_sequencer_pkg.sv
// Shared types and pitch tables for the sound sequencer and its tone divider.
// Rows of JINGLE_HP are indexed by event_e; columns by note index 0..3.
package sound_sequencer_pkg;

    localparam int unsigned HpW = 16;

    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StTone = 2'd1;
    localparam state_t StLoad = 2'd2;
    localparam state_t StPlay = 2'd3;

    typedef enum logic [1:0] {
        EvStart = 2'd0,
        EvHs    = 2'd1,
        EvWin   = 2'd2,
        EvLose  = 2'd3
    } event_e;

    localparam logic [HpW-1:0] COLOR_HP [4] = '{16'd19111, 16'd15169, 16'd12755, 16'd9556};

    // A half-period of 0 is a rest.
    localparam logic [HpW-1:0] JINGLE_HP [4][4] = '{
        '{16'd19111, 16'd15169, 16'd12755, 16'd9556},
        '{16'd12755, 16'd0,     16'd12755, 16'd9556},
        '{16'd15169, 16'd12755, 16'd9556,  16'd9556},
        '{16'd9556,  16'd12755, 16'd15169, 16'd19111}
    };

    function automatic logic [HpW-1:0] jingle_hp(input event_e ev, input logic [1:0] note);
        return JINGLE_HP[ev][note];
    endfunction

    function automatic event_e prio_sel(input logic [3:0] pend);
        if (pend[EvLose]) return EvLose;
        if (pend[EvWin])  return EvWin;
        if (pend[EvHs])   return EvHs;
        return EvStart;
    endfunction

endpackage

// File: rtl/sound_sequencer_tone_gen.sv
// Square-wave divider: SQ toggles every HP cycles; HP of 0 holds SQ low.
// Any change of HP restarts the phase with SQ low.
module tone_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [DIV_W-1:0] HP,
    output logic             SQ
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hp_q;
    logic             sq_q, sq_d;

    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (HP != hp_q || HP == '0) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (cnt_q == HP - 1'b1) begin
            cnt_d = '0;
            sq_d  = ~sq_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            hp_q  <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hp_q  <= HP;
            sq_q  <= sq_d;
        end
    end

    assign SQ = sq_q;

endmodule

// File: rtl/sound_sequencer.sv
// Jingle/colour-tone sequencer driving a square-wave speaker.
// Define IV_MELODY_EN to play all four ROM notes; otherwise note 0 is held for the whole jingle.
module sound_sequencer
    import sound_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned NOTE_TICKS = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TICK,
    input  logic       COLOR_REQ,
    input  logic [1:0] COLOR,
    input  logic       START_REQ,
    input  logic       HS_REQ,
    input  logic       WIN_REQ,
    input  logic       LOSE_REQ,
    input  logic       MUTE,
    output logic       SPK,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned TW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [TW-1:0] TickLast = TW'(NOTE_TICKS - 1);

    state_t        state_q, state_d;
    logic [3:0]    pend_q, pend_d;
    event_e        ev_q, ev_d;
    logic [1:0]    note_q, note_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          done_q, done_d;
    logic [3:0]    req_v, clr;
    logic [1:0]    note_sel;
    logic [DIV_W-1:0] hp;
    logic          sq;

`ifdef IV_MELODY_EN
    assign note_sel = note_q;
`else
    assign note_sel = 2'd0;
`endif

    always_comb begin
        state_d = state_q;
        ev_d    = ev_q;
        note_d  = note_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        clr     = '0;
        req_v   = {LOSE_REQ, WIN_REQ, HS_REQ, START_REQ};
        if (state_q == StPlay) begin
            req_v[ev_q] = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    state_d = StLoad;
                end else if (COLOR_REQ) begin
                    state_d = StTone;
                end
            end
            StTone: begin
                if (|pend_q) begin
                    state_d = StLoad;
                end else if (!COLOR_REQ) begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                note_d = 2'd0;
                tick_d = '0;
                if (|pend_q) begin
                    ev_d       = prio_sel(pend_q);
                    clr[ev_d]  = 1'b1;
                    state_d    = StPlay;
                end else begin
                    state_d = StIdle;
                end
            end
            StPlay: begin
                if (TICK) begin
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        if (note_q == 2'd3) begin
                            note_d  = 2'd0;
                            done_d  = 1'b1;
                            state_d = (|pend_q) ? StLoad : StIdle;
                        end else begin
                            note_d = note_q + 2'd1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A request arriving in the load cycle survives the clear.
        pend_d = (pend_q & ~clr) | req_v;
    end

    always_comb begin
        hp = '0;
        case (state_q)
            StTone: begin
                if (COLOR_REQ && !(|pend_q)) begin
                    hp = DIV_W'(COLOR_HP[COLOR]);
                end
            end
            StPlay:  hp = DIV_W'(jingle_hp(ev_q, note_sel));
            default: hp = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            pend_q  <= '0;
            ev_q    <= EvStart;
            note_q  <= 2'd0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ev_q    <= ev_d;
            note_q  <= note_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    tone_gen #(
        .DIV_W(DIV_W)
    ) u_tone (
        .CLK  (CLK),
        .RST_N(RST_N),
        .HP   (hp),
        .SQ   (sq)
    );

    assign SPK  = sq & ~MUTE;
    assign BUSY = (state_q != StIdle);
    assign DONE = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: colour tone timing, jingle priority/queueing,
// mute, and asynchronous reset. Expected note pitches flow through a scoreboard queue.
module tb_sound_sequencer;
    import sound_sequencer_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       TICK = 1'b0;
    logic       COLOR_REQ = 1'b0;
    logic [1:0] COLOR = 2'd0;
    logic       START_REQ = 1'b0;
    logic       HS_REQ = 1'b0;
    logic       WIN_REQ = 1'b0;
    logic       LOSE_REQ = 1'b0;
    logic       MUTE = 1'b0;
    logic       SPK, BUSY, DONE;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int unsigned exp_q[$];

    int unsigned rom [4][4] = '{
        '{19111, 15169, 12755, 9556},
        '{12755, 0,     12755, 9556},
        '{15169, 12755, 9556,  9556},
        '{9556,  12755, 15169, 19111}
    };

    sound_sequencer #(
        .DIV_W     (16),
        .NOTE_TICKS(8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .TICK     (TICK),
        .COLOR_REQ(COLOR_REQ),
        .COLOR    (COLOR),
        .START_REQ(START_REQ),
        .HS_REQ   (HS_REQ),
        .WIN_REQ  (WIN_REQ),
        .LOSE_REQ (LOSE_REQ),
        .MUTE     (MUTE),
        .SPK      (SPK),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (DONE) done_cnt <= done_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_jingle(input int ev);
        for (int n = 0; n < 4; n++) begin
`ifdef IV_MELODY_EN
            exp_q.push_back(rom[ev][n]);
`else
            exp_q.push_back(rom[ev][0]);
`endif
        end
    endtask

    task automatic wait_load(input string tag);
        int n = 0;
        while (dut.state_q !== StLoad && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(dut.state_q), 32'(StLoad));
    endtask

    task automatic wait_spk(input logic v, input string tag, output int t);
        int n = 0;
        while (SPK !== v && n < 30000) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(SPK), 32'(v));
        t = cyc;
    endtask

    // Entered at a negedge with the DUT in LOAD; leaves at the negedge DONE should be high.
    task automatic play_jingle(input string tag, input bit inject, output int spk_hi);
        int unsigned hp_exp;
        spk_hi = 0;
        @(negedge CLK);
        for (int n = 0; n < 4; n++) begin
            hp_exp = 32'hffff_ffff;
            if (exp_q.size() > 0) hp_exp = exp_q.pop_front();
            chk({tag, " note hp"}, 32'(dut.u_tone.HP), hp_exp);
            for (int t = 0; t < 8; t++) begin
                if (!(n == 0 && t == 0)) begin
                    @(negedge CLK);
                    if (SPK) spk_hi++;
                end
                TICK = 1'b1;
                if (inject && n == 1 && t == 2) WIN_REQ = 1'b1;
                if (inject && n == 2 && t == 2) begin
                    HS_REQ = 1'b1;
                    push_jingle(EvHs);
                end
                @(negedge CLK);
                TICK = 1'b0;
                WIN_REQ = 1'b0;
                HS_REQ = 1'b0;
                if (SPK) spk_hi++;
            end
        end
        chk({tag, " done"}, 32'(DONE), 1);
    endtask

    initial begin
        int t_r1, t_f1, t_r2, t_r3, t0, d0, spk_hi;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst spk", 32'(SPK), 0);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst done", 32'(DONE), 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Colour tone, COLOR=2: half-period 12755, period 25510
        COLOR = 2'd2;
        COLOR_REQ = 1'b1;
        @(negedge CLK);
        chk("tone busy", 32'(BUSY), 1);
        wait_spk(1'b1, "tone rise1", t_r1);
        wait_spk(1'b0, "tone fall1", t_f1);
        wait_spk(1'b1, "tone rise2", t_r2);
        chk("tone high half", 32'(t_f1 - t_r1), 12755);
        chk("tone period", 32'(t_r2 - t_r1), 25510);
        MUTE = 1'b1;
        #1 chk("mute spk", 32'(SPK), 0);
        MUTE = 1'b0;
        #1 chk("unmute spk", 32'(SPK), 1);
        COLOR = 2'd3;
        #1 chk("color3 hp", 32'(dut.u_tone.HP), 9556);
        @(negedge CLK);
        chk("restart low", 32'(SPK), 0);
        t0 = cyc;
        wait_spk(1'b1, "tone3 rise", t_r3);
        chk("tone3 half", 32'(t_r3 - t0), 9556);
        COLOR_REQ = 1'b0;
        @(negedge CLK);
        chk("off spk", 32'(SPK), 0);
        @(negedge CLK);
        chk("off busy", 32'(BUSY), 0);

        // START and LOSE together: LOSE first, then START
        START_REQ = 1'b1;
        LOSE_REQ = 1'b1;
        push_jingle(EvLose);
        push_jingle(EvStart);
        t0 = cyc;
        d0 = done_cnt;
        @(negedge CLK);
        START_REQ = 1'b0;
        LOSE_REQ = 1'b0;
        wait_load("lose load");
        play_jingle("lose", 1'b0, spk_hi);
        chk("lose latency", 32'(cyc - t0), 66);
        wait_load("start load");
        play_jingle("start", 1'b0, spk_hi);
        @(negedge CLK);
        chk("pair idle", 32'(BUSY), 0);
        chk("done one cycle", 32'(DONE), 0);
        chk("pair dones", 32'(done_cnt - d0), 2);

        // WIN preempts a colour tone; tone resumes afterwards
        COLOR = 2'd1;
        COLOR_REQ = 1'b1;
        repeat (5) @(negedge CLK);
        chk("tone1 busy", 32'(BUSY), 1);
        chk("tone1 hp", 32'(dut.u_tone.HP), 15169);
        WIN_REQ = 1'b1;
        push_jingle(EvWin);
        d0 = done_cnt;
        @(negedge CLK);
        WIN_REQ = 1'b0;
        @(negedge CLK);
        chk("preempt spk", 32'(SPK), 0);
        chk("preempt load", 32'(dut.state_q), 32'(StLoad));
        play_jingle("win tone", 1'b0, spk_hi);
        chk("win via idle", 32'(BUSY), 0);
        @(negedge CLK);
        chk("tone resume", 32'(BUSY), 1);
        chk("tone resume hp", 32'(dut.u_tone.HP), 15169);
        COLOR_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        chk("win tone dones", 32'(done_cnt - d0), 1);

        // WIN repeated during WIN is dropped; HS during WIN queues
        WIN_REQ = 1'b1;
        push_jingle(EvWin);
        d0 = done_cnt;
        @(negedge CLK);
        WIN_REQ = 1'b0;
        wait_load("win load");
        play_jingle("win inj", 1'b1, spk_hi);
        wait_load("hs load");
        play_jingle("hs", 1'b0, spk_hi);
        @(negedge CLK);
        @(negedge CLK);
        chk("hs idle", 32'(BUSY), 0);
        chk("win hs dones", 32'(done_cnt - d0), 2);
        chk("scoreboard empty", 32'(exp_q.size()), 0);

        // Muted LOSE: silent, DONE timing unchanged
        MUTE = 1'b1;
        LOSE_REQ = 1'b1;
        push_jingle(EvLose);
        t0 = cyc;
        @(negedge CLK);
        LOSE_REQ = 1'b0;
        wait_load("mlose load");
        play_jingle("mlose", 1'b0, spk_hi);
        chk("mlose latency", 32'(cyc - t0), 66);
        chk("mlose silent", 32'(spk_hi), 0);
        MUTE = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset mid-note with HS pending
        START_REQ = 1'b1;
        push_jingle(EvStart);
        @(negedge CLK);
        START_REQ = 1'b0;
        wait_load("rst load");
        @(negedge CLK);
        repeat (3) begin
            TICK = 1'b1;
            @(negedge CLK);
            TICK = 1'b0;
            @(negedge CLK);
        end
        HS_REQ = 1'b1;
        @(negedge CLK);
        HS_REQ = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("async busy", 32'(BUSY), 0);
        chk("async spk", 32'(SPK), 0);
        chk("async done", 32'(DONE), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        repeat (40) begin
            TICK = 1'b1;
            @(negedge CLK);
            TICK = 1'b0;
            @(negedge CLK);
        end
        chk("post rst idle", 32'(BUSY), 0);
        chk("post rst no done", 32'(done_cnt - d0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
